// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// operand width, funct3 opcodes, FSM state encoding and operand-signedness helpers.
package muldiv_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_e;

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM
  function automatic logic a_is_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM
  function automatic logic b_is_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide execute unit.
// Operands are latched as magnitudes on start; 32 shift-add (multiply) or
// restoring (divide) iterations follow, then the sign-fixed result is written
// back through a one-cycle regfile write pulse. Latency is fixed for all ops.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, funct3   request (taken only in IDLE) and M-extension op select
//   a, b, rd        rs1 / rs2 values and destination index
//   busy            high while RUN or WB
//   wen, dsel, d    regfile write enable pulse, write index, write data
module muldiv_unit #(
  parameter int unsigned XLEN = muldiv_unit_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd,
  output logic            busy,
  output logic            wen,
  output logic [4:0]      dsel,
  output logic [XLEN-1:0] d
);
  import muldiv_unit_pkg::*;

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned PW    = 2 * XLEN;

  state_e state, state_next;

  logic [CNT_W-1:0] cnt;
  logic [2:0]       op;
  logic             neg;       // result needs two's-complement negation
  logic             spec_hit;  // divide-by-zero or signed overflow detected at start
  logic [XLEN-1:0]  spec_val;
  logic [XLEN-1:0]  mcand;     // multiplicand / divisor magnitude
  logic [PW-1:0]    prod;      // {partial product, remaining multiplier bits}
  logic [XLEN-1:0]  rem;       // divider partial remainder
  logic [XLEN-1:0]  quo;       // dividend bits shifted out, quotient bits shifted in

  logic            start_ok, last;
  logic            a_sgn, b_sgn, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   add_sum, shifted;
  logic            ge;
  logic [PW-1:0]   prod_step, prod_fix;
  logic [XLEN-1:0] rem_step, quo_step, rem_fix, quo_fix, sel, result;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == CNT_W'(XLEN - 1)) state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand conditioning and special-case detection at start
  always_comb begin
    start_ok = (state == IDLE) && start;
    last     = (state == RUN) && (cnt == CNT_W'(XLEN - 1));
    a_sgn    = a_is_signed(funct3) && a[XLEN-1];
    b_sgn    = b_is_signed(funct3) && b[XLEN-1];
    a_mag    = a_sgn ? (~a + XLEN'(1)) : a;
    b_mag    = b_sgn ? (~b + XLEN'(1)) : b;
    div_zero = funct3[2] && (b == '0);
    div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
               (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    // funct3[1] distinguishes REM/REMU from DIV/DIVU
    if (funct3[1]) spec_val = div_zero ? a : '0;
    else           spec_val = div_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // One multiply and one divide iteration, plus final sign fix and select
  always_comb begin
    add_sum   = {1'b0, prod[PW-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_step = {add_sum, prod[XLEN-1:1]};

    shifted  = {rem, quo[XLEN-1]};
    ge       = shifted >= {1'b0, mcand};
    rem_step = ge ? XLEN'(shifted - {1'b0, mcand}) : shifted[XLEN-1:0];
    quo_step = {quo[XLEN-2:0], ge};

    prod_fix = neg ? (~prod_step + PW'(1)) : prod_step;
    quo_fix  = neg ? (~quo_step + XLEN'(1)) : quo_step;
    rem_fix  = neg ? (~rem_step + XLEN'(1)) : rem_step;

    case (op)
      F3_MUL:                      sel = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: sel = prod_fix[PW-1:XLEN];
      F3_DIV, F3_DIVU:             sel = quo_fix;
      default:                     sel = rem_fix;
    endcase
    result = spec_hit ? spec_val : sel;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      op       <= '0;
      neg      <= 1'b0;
      spec_hit <= 1'b0;
      mcand    <= '0;
      prod     <= '0;
      rem      <= '0;
      quo      <= '0;
      busy     <= 1'b0;
      wen      <= 1'b0;
      dsel     <= '0;
      d        <= '0;
    end else begin
      busy <= (state_next != IDLE);
      wen  <= (state_next == WB) && (dsel != '0);
      if (start_ok) begin
        op       <= funct3;
        dsel     <= rd;
        // remainder sign follows the dividend; everything else is sign(a)^sign(b)
        neg      <= (funct3[2] && funct3[1]) ? a_sgn : (a_sgn ^ b_sgn);
        spec_hit <= div_zero || div_ovf;
        mcand    <= b_mag;
        prod     <= {{XLEN{1'b0}}, a_mag};
        rem      <= '0;
        quo      <= a_mag;
        cnt      <= '0;
      end else if (state == RUN) begin
        cnt  <= cnt + CNT_W'(1);
        prod <= prod_step;
        rem  <= rem_step;
        quo  <= quo_step;
        if (last) d <= result;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: results, write-back timing,
// busy window, rd=0 suppression, ignored start while busy, and mid-op reset.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  rd = '0;
  logic        busy, wen;
  logic [4:0]  dsel;
  logic [31:0] d;

  int checks = 0;
  int failures = 0;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .a(a), .b(b), .rd(rd),
    .busy(busy), .wen(wen), .dsel(dsel), .d(d)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op from an idle sampling point (#1 after an edge) and watch 40 cycles.
  // Cycle k is the sample taken #1 after edge E(k-1); the start edge is E0.
  // glitch > 0 drives a stray start (different rd/op) during cycle 'glitch'.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] av,
                        input logic [31:0] bv, input logic [4:0] rdv,
                        input logic [31:0] exp_d, input int glitch);
    int busy_cnt = 0;
    int wen_cnt = 0;
    int wen_cyc = 0;
    logic [31:0] d_at = '0;
    logic [4:0]  dsel_at = '0;
    start = 1'b1; funct3 = f3; a = av; b = bv; rd = rdv;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) begin
        @(posedge clk); #1;
      end
      if (busy) busy_cnt++;
      if (wen) begin
        wen_cnt++;
        if (wen_cyc == 0) wen_cyc = k;
      end
      if (k == 33) begin
        d_at = d;
        dsel_at = dsel;
      end
      start = (k == glitch);
      if (k == glitch) begin
        funct3 = F3_DIV; a = 32'h0000_0063; b = 32'h0000_0003; rd = rdv ^ 5'd3;
      end
    end
    check_eq({tag, "_d"}, d_at, exp_d);
    check_eq({tag, "_dsel"}, 32'(dsel_at), 32'(rdv));
    check_eq({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
    check_eq({tag, "_wen_count"}, 32'(wen_cnt), (rdv != 5'd0) ? 32'd1 : 32'd0);
    check_eq({tag, "_wen_cycle"}, 32'(wen_cyc), (rdv != 5'd0) ? 32'd33 : 32'd0);
  endtask

  initial begin
    int wen_seen;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_wen", 32'(wen), 32'd0);
    check_eq("reset_dsel", 32'(dsel), 32'd0);
    check_eq("reset_d", d, 32'd0);

    run_op("mul_neg",    F3_MUL,    32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 0);
    run_op("mulhu_max",  F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 0);
    run_op("mulh_m1",    F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000, 0);
    run_op("mulhsu",     F3_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd8,  32'hFFFF_FFFF, 0);
    run_op("div_neg",    F3_DIV,    32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFD, 0);
    run_op("rem_neg",    F3_REM,    32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFF, 0);
    run_op("divu",       F3_DIVU,   32'd100,       32'd7,         5'd12, 32'd14,        0);
    run_op("remu",       F3_REMU,   32'd100,       32'd7,         5'd13, 32'd2,         0);
    run_op("div_by0",    F3_DIV,    32'd5,         32'd0,         5'd14, 32'hFFFF_FFFF, 0);
    run_op("divn_by0",   F3_DIV,    32'hFFFF_FFFB, 32'd0,         5'd15, 32'hFFFF_FFFF, 0);
    run_op("remu_by0",   F3_REMU,   32'd5,         32'd0,         5'd16, 32'd5,         0);
    run_op("remn_by0",   F3_REM,    32'hFFFF_FFFB, 32'd0,         5'd17, 32'hFFFF_FFFB, 0);
    run_op("div_ovf",    F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000, 0);
    run_op("rem_ovf",    F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h0000_0000, 0);
    run_op("mul_rd0",    F3_MUL,    32'd3,         32'd4,         5'd0,  32'd12,        0);
    run_op("mul_ignore", F3_MUL,    32'd6,         32'd7,         5'd9,  32'd42,        10);

    // Reset in cycle 10 of a DIV: state and outputs clear, no write afterwards
    start = 1'b1; funct3 = F3_DIV; a = 32'd100; b = 32'd7; rd = 5'd21;
    @(posedge clk); #1;
    start = 1'b0;
    wen_seen = 0;
    for (int k = 1; k < 10; k++) begin
      @(posedge clk); #1;
      if (wen) wen_seen++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_wen", 32'(wen), 32'd0);
    check_eq("midrst_dsel", 32'(dsel), 32'd0);
    check_eq("midrst_d", d, 32'd0);
    @(posedge clk); #1;
    if (wen) wen_seen++;
    check_eq("midrst_idle_busy", 32'(busy), 32'd0);
    check_eq("midrst_no_write", 32'(wen_seen), 32'd0);
    run_op("post_rst_div", F3_DIV, 32'hFFFF_FF9C, 32'd7, 5'd4, 32'hFFFF_FFF2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
